// File: rtl/egress_width_reducer_if.sv
// Frame-buffer read side and MAC TX side of the egress width reducer.
// The master modport is the reducer's view; slave is the surrounding fabric.
interface egress_width_reducer_if;
  logic         mem_frame_ready;
  logic [10:0]  mem_frame_bytelen;
  logic         mem_frame_start;
  logic         mem_rd_en;
  logic         mem_valid;
  logic [127:0] mem_data;
  logic         tx_ready;
  logic         tx_bus_start;
  logic         tx_bus_data_valid;
  logic [2:0]   tx_bus_bytes_valid;
  logic [31:0]  tx_bus_data;
  logic         tx_frame_sent;
  logic         tx_frame_dropped;

  modport master (
    input  mem_frame_ready, mem_frame_bytelen, mem_valid, mem_data, tx_ready,
    output mem_frame_start, mem_rd_en, tx_bus_start, tx_bus_data_valid,
           tx_bus_bytes_valid, tx_bus_data, tx_frame_sent, tx_frame_dropped
  );

  modport slave (
    output mem_frame_ready, mem_frame_bytelen, mem_valid, mem_data, tx_ready,
    input  mem_frame_start, mem_rd_en, tx_bus_start, tx_bus_data_valid,
           tx_bus_bytes_valid, tx_bus_data, tx_frame_sent, tx_frame_dropped
  );
endinterface

// File: rtl/egress_width_reducer.sv
// Pulls one frame from the 128-bit frame buffer and serializes it MSB-lane first
// onto the 32-bit MAC TX bus, with a 2-entry word buffer absorbing tx_ready stalls.
//   state   | meaning
//   IDLE    | waiting for a frame
//   SEND    | reading words and emitting beats
//   DISCARD | reading words and throwing them away
module egress_width_reducer #(
  parameter int MAX_FRAME_SIZE = 1522
) (
  input  logic clk,
  input  logic rst_n,
  egress_width_reducer_if.master bus
);
  localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME_SIZE);

  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;

  state_t       r_state;
  logic [10:0]  r_remaining;
  logic [7:0]   r_wordcount, r_words_req, r_words_rcv;
  logic [1:0]   r_occ, r_inflight, r_lane;
  logic         r_wr_ptr, r_rd_ptr, r_last_beat;
  logic [127:0] r_buf [2];
  logic         r_frame_start, r_rd_en, r_tx_start, r_tx_valid, r_sent, r_dropped;
  logic [2:0]   r_tx_bytes;
  logic [31:0]  r_tx_data;

  logic         w_arrive, w_full, w_push, w_head_avail, w_beat, w_final, w_pop, w_req;
  logic         w_bad_len;
  logic [127:0] w_head;
  logic [31:0]  w_lane_data;
  logic [2:0]   w_occ_next, w_inf_next, w_bytes;
  logic [7:0]   w_wordcount;

  // A word arriving into an empty buffer is usable as the head in the same cycle.
  assign w_arrive     = bus.mem_valid && (r_inflight != 2'd0);
  assign w_full       = (r_occ == 2'd2);
  assign w_push       = w_arrive && (r_state == SEND) && !w_full;
  assign w_head_avail = (r_occ != 2'd0) || w_push;
  assign w_head       = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : bus.mem_data;
  assign w_final      = (r_remaining <= 11'd4);
  assign w_beat       = (r_state == SEND) && !r_last_beat && bus.tx_ready && w_head_avail;
  assign w_pop        = w_beat && ((r_lane == 2'd3) || w_final);
  assign w_occ_next   = {1'b0, r_occ} + {2'b0, w_push} - {2'b0, w_pop};
  assign w_inf_next   = {1'b0, r_inflight} - {2'b0, w_arrive};
  assign w_req        = (r_state != IDLE) && (r_words_req < r_wordcount) &&
                        ((w_occ_next + w_inf_next) < 3'd2);
  assign w_bytes      = w_final ? r_remaining[2:0] : 3'd4;
  assign w_wordcount  = {1'b0, bus.mem_frame_bytelen[10:4]} +
                        {7'b0, (bus.mem_frame_bytelen[3:0] != 4'd0)};
  assign w_bad_len    = (bus.mem_frame_bytelen == 11'd0) ||
                        ({1'b0, bus.mem_frame_bytelen} > MAX_LEN);

  always_comb begin
    w_lane_data = '0;
    case (r_lane)
      2'd0: w_lane_data = w_head[127:96];
      2'd1: w_lane_data = w_head[95:64];
      2'd2: w_lane_data = w_head[63:32];
      2'd3: w_lane_data = w_head[31:0];
      default: w_lane_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= bus.mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_wordcount   <= '0;
      r_words_req   <= '0;
      r_words_rcv   <= '0;
      r_occ         <= '0;
      r_inflight    <= '0;
      r_lane        <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_last_beat   <= 1'b0;
      r_frame_start <= 1'b0;
      r_rd_en       <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_bytes    <= '0;
      r_tx_data     <= '0;
      r_sent        <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_bytes    <= '0;
      r_tx_data     <= '0;
      r_sent        <= 1'b0;
      r_dropped     <= 1'b0;
      r_rd_en       <= w_req;
      r_occ         <= w_occ_next[1:0];
      r_inflight    <= w_inf_next[1:0] + {1'b0, w_req};
      if (w_req)  r_words_req <= r_words_req + 8'd1;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;

      case (r_state)
        IDLE: begin
          if (bus.mem_frame_ready) begin
            r_remaining   <= bus.mem_frame_bytelen;
            r_wordcount   <= w_wordcount;
            r_words_req   <= '0;
            r_words_rcv   <= '0;
            r_lane        <= '0;
            r_last_beat   <= 1'b0;
            r_frame_start <= 1'b1;
            if (w_bad_len) begin
              r_state <= DISCARD;
            end else begin
              r_tx_start <= 1'b1;
              r_state    <= SEND;
            end
          end
        end
        SEND: begin
          if (r_last_beat) begin
            r_sent  <= 1'b1;
            r_state <= IDLE;
          end else if (w_beat) begin
            r_tx_valid  <= 1'b1;
            r_tx_data   <= w_lane_data;
            r_tx_bytes  <= w_bytes;
            r_lane      <= r_lane + 2'd1;
            r_remaining <= w_final ? 11'd0 : (r_remaining - 11'd4);
            r_last_beat <= w_final;
          end
        end
        DISCARD: begin
          if (w_arrive) r_words_rcv <= r_words_rcv + 8'd1;
          if ((r_wordcount == 8'd0) || (w_arrive && (r_words_rcv + 8'd1 == r_wordcount))) begin
            r_dropped <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_frame_start    = r_frame_start;
  assign bus.mem_rd_en          = r_rd_en;
  assign bus.tx_bus_start       = r_tx_start;
  assign bus.tx_bus_data_valid  = r_tx_valid;
  assign bus.tx_bus_bytes_valid = r_tx_bytes;
  assign bus.tx_bus_data        = r_tx_data;
  assign bus.tx_frame_sent      = r_sent;
  assign bus.tx_frame_dropped   = r_dropped;
endmodule

// File: tb/tb_egress_width_reducer.sv
// Bench for egress_width_reducer: a frame-buffer model serves random frame bytes and
// the emitted beat stream is compared byte-for-byte with the accepted frames.
module tb_egress_width_reducer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  egress_width_reducer_if ifc();

  egress_width_reducer #(.MAX_FRAME_SIZE(1522)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int n_start, n_txs, n_rd, n_beats, n_sent, n_drop, n_valid;
  int start_cyc, txs_cyc, first_rd_cyc, first_beat_cyc, last_beat_cyc, sent_cyc, rdy_cyc;
  int gap_at_start;
  int bv_err, data_err, idle_err, occ_err;
  int rd_frame, beats_frame, tx_left, cur_len, words_served;

  logic [7:0]   cur_bytes [0:2047];
  logic [7:0]   exp_q [$];
  int           offer_q [$];
  bit           rdy_rand = 1'b0;
  logic         nxt_valid = 1'b0;
  logic [127:0] nxt_data = '0;

  // Memory model, frame offering and beat scoreboard, all on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (ifc.mem_frame_start) begin
      n_start++;
      start_cyc = cyc;
      cur_len = int'(ifc.mem_frame_bytelen);
      words_served = 0;
      rd_frame = 0;
      beats_frame = 0;
      first_rd_cyc = -1;
      first_beat_cyc = -1;
      for (int i = 0; i < 2048; i++) cur_bytes[i] = 8'($urandom);
      if (cur_len >= 1 && cur_len <= 1522)
        for (int i = 0; i < cur_len; i++) exp_q.push_back(cur_bytes[i]);
      ifc.mem_frame_ready = 1'b0;
    end
    if (ifc.tx_bus_start) begin
      n_txs++;
      txs_cyc = cyc;
      tx_left = cur_len;
      if (n_beats > 0) gap_at_start = cyc - last_beat_cyc;
    end
    if (!ifc.mem_frame_ready && offer_q.size() > 0 && rst_n) begin
      ifc.mem_frame_ready = 1'b1;
      ifc.mem_frame_bytelen = 11'(offer_q.pop_front());
      rdy_cyc = cyc;
    end
    if (ifc.mem_rd_en) begin
      n_rd++;
      rd_frame++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      for (int j = 0; j < 16; j++)
        nxt_data[127-8*j -: 8] = cur_bytes[(16*words_served + j) % 2048];
      words_served++;
      nxt_valid = 1'b1;
    end else begin
      nxt_valid = 1'b0;
      nxt_data = '0;
    end
    if (ifc.mem_valid) n_valid++;
    if (ifc.tx_bus_data_valid) begin
      int exp_bv, nb;
      n_beats++;
      beats_frame++;
      last_beat_cyc = cyc;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      exp_bv = (tx_left >= 4) ? 4 : tx_left;
      if (int'(ifc.tx_bus_bytes_valid) != exp_bv) bv_err++;
      nb = (int'(ifc.tx_bus_bytes_valid) > 4) ? 4 : int'(ifc.tx_bus_bytes_valid);
      for (int b = 0; b < nb; b++) begin
        if (exp_q.size() == 0) data_err++;
        else if (ifc.tx_bus_data[31-8*b -: 8] !== exp_q.pop_front()) data_err++;
      end
      tx_left = tx_left - exp_bv;
    end else if (ifc.tx_bus_data !== 32'd0 || ifc.tx_bus_bytes_valid !== 3'd0) begin
      idle_err++;
    end
    if (rd_frame - beats_frame / 4 > 2) occ_err++;
    if (ifc.tx_frame_sent) begin
      n_sent++;
      sent_cyc = cyc;
    end
    if (ifc.tx_frame_dropped) n_drop++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    ifc.mem_valid = nxt_valid;
    ifc.mem_data  = nxt_data;
    ifc.tx_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic clear_stats();
    n_start = 0; n_txs = 0; n_rd = 0; n_beats = 0; n_sent = 0; n_drop = 0; n_valid = 0;
    start_cyc = 0; txs_cyc = 0; first_rd_cyc = -1; first_beat_cyc = -1;
    last_beat_cyc = 0; sent_cyc = 0; rdy_cyc = 0; gap_at_start = -1;
    bv_err = 0; data_err = 0; idle_err = 0; occ_err = 0;
    rd_frame = 0; beats_frame = 0;
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while ((n_sent + n_drop) < target && i < 3000) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [44:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {ifc.mem_frame_start, ifc.mem_rd_en, ifc.tx_bus_start, ifc.tx_bus_data_valid,
            ifc.tx_bus_bytes_valid, ifc.tx_bus_data, ifc.tx_frame_sent, ifc.tx_frame_dropped};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    clear_stats();
    rdy_rand = 1'b0;
    offer_q.push_back(64);
    wait_done(1);
    checks++; if (n_sent !== 1) begin errors++; $display("FAIL full_sent: got %0d expected 1", n_sent); end
    checks++; if (n_start !== 1) begin errors++; $display("FAIL full_starts: got %0d expected 1", n_start); end
    checks++; if (n_rd !== 4) begin errors++; $display("FAIL full_reads: got %0d expected 4", n_rd); end
    checks++; if (n_beats !== 16) begin errors++; $display("FAIL full_beats: got %0d expected 16", n_beats); end
    checks++; if (last_beat_cyc - first_beat_cyc !== 15) begin errors++; $display("FAIL full_contiguous: got span %0d expected 15", last_beat_cyc - first_beat_cyc); end
    checks++; if (bv_err !== 0) begin errors++; $display("FAIL full_bytes_valid: got %0d bad beats expected 0", bv_err); end
    checks++; if (data_err !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL full_data: got %0d bad bytes, %0d left expected 0/0", data_err, exp_q.size()); end
    checks++; if (start_cyc - rdy_cyc !== 1) begin errors++; $display("FAIL full_start_latency: got %0d expected 1", start_cyc - rdy_cyc); end
    checks++; if (txs_cyc !== start_cyc) begin errors++; $display("FAIL full_tx_start_cycle: got %0d expected %0d", txs_cyc, start_cyc); end
    checks++; if (first_rd_cyc - start_cyc !== 1) begin errors++; $display("FAIL full_first_read: got %0d expected 1", first_rd_cyc - start_cyc); end
    checks++; if (first_beat_cyc - start_cyc !== 3) begin errors++; $display("FAIL full_first_beat: got %0d expected 3", first_beat_cyc - start_cyc); end
    checks++; if (sent_cyc - last_beat_cyc !== 1) begin errors++; $display("FAIL full_sent_timing: got %0d expected 1", sent_cyc - last_beat_cyc); end
    checks++; if (idle_err !== 0) begin errors++; $display("FAIL full_idle_bus: got %0d dirty cycles expected 0", idle_err); end
  endtask

  task automatic test_partial();
    int lens [4];
    lens[0] = 61; lens[1] = 17; lens[2] = 1; lens[3] = 1522;
    rdy_rand = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clear_stats();
      offer_q.push_back(lens[k]);
      wait_done(1);
      checks++; if (n_sent !== 1) begin errors++; $display("FAIL partial_sent len=%0d: got %0d expected 1", lens[k], n_sent); end
      checks++; if (n_rd !== (lens[k] + 15) / 16) begin errors++; $display("FAIL partial_reads len=%0d: got %0d expected %0d", lens[k], n_rd, (lens[k] + 15) / 16); end
      checks++; if (n_beats !== (lens[k] + 3) / 4) begin errors++; $display("FAIL partial_beats len=%0d: got %0d expected %0d", lens[k], n_beats, (lens[k] + 3) / 4); end
      checks++; if (bv_err !== 0) begin errors++; $display("FAIL partial_bytes_valid len=%0d: got %0d bad beats expected 0", lens[k], bv_err); end
      checks++; if (data_err !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL partial_data len=%0d: got %0d bad, %0d left expected 0/0", lens[k], data_err, exp_q.size()); end
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    rdy_rand = 1'b1;
    offer_q.push_back(256);
    wait_done(1);
    rdy_rand = 1'b0;
    checks++; if (n_beats !== 64) begin errors++; $display("FAIL bp_beats: got %0d expected 64", n_beats); end
    checks++; if (n_rd !== 16 || n_valid !== 16) begin errors++; $display("FAIL bp_reads: got %0d/%0d expected 16/16", n_rd, n_valid); end
    checks++; if (data_err !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_data: got %0d bad, %0d left expected 0/0", data_err, exp_q.size()); end
    checks++; if (occ_err !== 0) begin errors++; $display("FAIL bp_occupancy: got %0d over-committed cycles expected 0", occ_err); end
    checks++; if (bv_err !== 0 || idle_err !== 0) begin errors++; $display("FAIL bp_beat_format: got %0d/%0d expected 0/0", bv_err, idle_err); end
  endtask

  task automatic test_discard();
    int lens [3];
    lens[0] = 1600; lens[1] = 0; lens[2] = 1523;
    rdy_rand = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clear_stats();
      offer_q.push_back(lens[k]);
      wait_done(1);
      checks++; if (n_drop !== 1 || n_sent !== 0) begin errors++; $display("FAIL discard_pulse len=%0d: got drop %0d sent %0d expected 1/0", lens[k], n_drop, n_sent); end
      checks++; if (n_rd !== (lens[k] + 15) / 16 || n_valid !== n_rd) begin errors++; $display("FAIL discard_reads len=%0d: got %0d/%0d expected %0d", lens[k], n_rd, n_valid, (lens[k] + 15) / 16); end
      checks++; if (n_txs !== 0 || n_beats !== 0 || idle_err !== 0) begin errors++; $display("FAIL discard_tx_quiet len=%0d: got start %0d beats %0d dirty %0d expected 0", lens[k], n_txs, n_beats, idle_err); end
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    rdy_rand = 1'b0;
    offer_q.push_back(64);
    offer_q.push_back(64);
    wait_done(2);
    checks++; if (n_sent !== 2) begin errors++; $display("FAIL b2b_sent: got %0d expected 2", n_sent); end
    checks++; if (n_beats !== 32) begin errors++; $display("FAIL b2b_beats: got %0d expected 32", n_beats); end
    checks++; if (gap_at_start !== 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", gap_at_start); end
    checks++; if (data_err !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad, %0d left expected 0/0", data_err, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [44:0] outs;
    int i = 0;
    clear_stats();
    rdy_rand = 1'b0;
    offer_q.push_back(64);
    while (n_beats < 8 && i < 500) begin
      @(negedge clk);
      i++;
    end
    checks++; if (n_beats < 8) begin errors++; $display("FAIL rst_mid_reach: got %0d beats expected 8", n_beats); end
    rst_n = 1'b0;
    #1;
    outs = {ifc.mem_frame_start, ifc.mem_rd_en, ifc.tx_bus_start, ifc.tx_bus_data_valid,
            ifc.tx_bus_bytes_valid, ifc.tx_bus_data, ifc.tx_frame_sent, ifc.tx_frame_dropped};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
    offer_q.delete();
    exp_q.delete();
    ifc.mem_frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_stats();
    offer_q.push_back(64);
    wait_done(1);
    checks++; if (n_sent !== 1 || n_beats !== 16) begin errors++; $display("FAIL rst_mid_resend: got sent %0d beats %0d expected 1/16", n_sent, n_beats); end
    checks++; if (data_err !== 0 || bv_err !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL rst_mid_data: got %0d/%0d/%0d expected 0/0/0", data_err, bv_err, exp_q.size()); end
  endtask

  initial begin
    ifc.mem_frame_ready = 1'b0;
    ifc.mem_frame_bytelen = '0;
    ifc.mem_valid = 1'b0;
    ifc.mem_data = '0;
    ifc.tx_ready = 1'b1;
    clear_stats();
    test_reset();
    test_full_frame();
    test_partial();
    test_backpressure();
    test_discard();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
